// File: rtl/unsigned_to_signed_rx_if.sv
// Sample hand-off bundle for unsigned_to_signed_rx: two independent valid/ready channels.
interface unsigned_to_signed_rx_if;
  logic [15:0] sample_a;
  logic [15:0] sample_b;
  logic        valid_a;
  logic        valid_b;
  logic        ready_a;
  logic        ready_b;

  modport master (output sample_a, sample_b, valid_a, valid_b, input ready_a, ready_b);
  modport slave  (input sample_a, sample_b, valid_a, valid_b, output ready_a, ready_b);
endinterface

// File: rtl/unsigned_to_signed_rx.sv
// Serial DAC-code receiver: decodes 16-bit frames into signed channel A/B samples.
// Optional offset removal with saturation is enabled by defining OFFSET_REMOVE_EN.
module unsigned_to_signed_rx #(
  parameter int FRAME_BITS  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    sdi,
  input  logic [15:0]             off1,
  input  logic [15:0]             off2,
  unsigned_to_signed_rx_if.master smp,
  output logic                    overrun,
  output logic                    frame_err
);
  localparam logic [4:0] FB = 5'(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SHIFT, DECODE, OUTPUT} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, cs_sync_reg, sdi_sync_reg;
  logic                   sclk_prev_reg, cs_prev_reg;
  logic                   sclk_s, cs_s, sdi_s;
  logic                   sclk_rise, cs_fall, cs_rise;

  logic [FRAME_BITS-1:0]  shift_reg;
  logic [4:0]             cnt_reg;
  logic                   frame_err_reg;
  logic [15:0]            dec_reg, dec_next;
  logic                   chan_reg;
  logic                   overrun_reg;

  logic cnt_clr, shift_en, err_set, decode_en, load_en;

  // sdi goes through the same depth as sclk so a bit stays aligned with its clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_reg <= '0;
      cs_sync_reg   <= '1;
      sdi_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      cs_prev_reg   <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  assign cs_rise   = cs_s & ~cs_prev_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cs_fall && en) state_next = SHIFT;
      SHIFT:   if (cs_rise) state_next = (cnt_reg == FB) ? DECODE : IDLE;
      DECODE:  state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_clr   = (state_reg == IDLE);
    shift_en  = (state_reg == SHIFT) && sclk_rise && !cs_s;
    err_set   = (state_reg == SHIFT) && cs_rise && (cnt_reg != FB);
    decode_en = (state_reg == DECODE);
    load_en   = (state_reg == OUTPUT);
  end

  // Counter parks at FRAME_BITS+1 so an over-long frame can never look complete
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg       <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= err_set;
      if (cnt_clr) begin
        cnt_reg <= '0;
      end else if (shift_en) begin
        if (cnt_reg < FB) begin
          shift_reg <= {shift_reg[FRAME_BITS-2:0], sdi_s};
          cnt_reg   <= cnt_reg + 5'd1;
        end else begin
          cnt_reg <= FB + 5'd1;
        end
      end
    end
  end

  logic [16:0] code17, raw17;
  assign code17 = {5'b0, shift_reg[11:0]};
  assign raw17  = shift_reg[FRAME_BITS-1] ? (code17 - 17'd2047) : (17'd2048 - code17);

`ifdef OFFSET_REMOVE_EN
  logic [15:0] off_sel;
  logic [16:0] diff17;
  assign off_sel = shift_reg[FRAME_BITS-1] ? off2 : off1;
  assign diff17  = raw17 - {off_sel[15], off_sel};
  always_comb begin
    dec_next = diff17[15:0];
    if (diff17[16] != diff17[15]) dec_next = diff17[16] ? 16'h8000 : 16'h7FFF;
  end
`else
  logic unused_off;
  assign unused_off = &{1'b0, off1, off2, raw17[16]};
  assign dec_next   = raw17[15:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_reg  <= '0;
      chan_reg <= 1'b0;
    end else if (decode_en) begin
      dec_reg  <= dec_next;
      chan_reg <= shift_reg[FRAME_BITS-1];
    end
  end

  logic [15:0] smp_reg [2];
  logic [1:0]  valid_reg, rdy, ovr_set;
  assign rdy = {smp.ready_b, smp.ready_a};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic load_hit;
    assign load_hit    = load_en && (chan_reg == 1'(gi));
    assign ovr_set[gi] = load_hit && valid_reg[gi] && !rdy[gi];

    // A new sample only displaces an unconsumed one when it is being handed off this cycle
    always_ff @(posedge clk) begin
      if (reset) begin
        smp_reg[gi]   <= '0;
        valid_reg[gi] <= 1'b0;
      end else if (load_hit && !(valid_reg[gi] && !rdy[gi])) begin
        smp_reg[gi]   <= dec_reg;
        valid_reg[gi] <= 1'b1;
      end else if (valid_reg[gi] && rdy[gi]) begin
        valid_reg[gi] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         overrun_reg <= 1'b0;
    else if (|ovr_set) overrun_reg <= 1'b1;
  end

  assign smp.sample_a = smp_reg[0];
  assign smp.sample_b = smp_reg[1];
  assign smp.valid_a  = valid_reg[0];
  assign smp.valid_b  = valid_reg[1];
  assign overrun      = overrun_reg;
  assign frame_err    = frame_err_reg;
endmodule

// File: tb/tb_unsigned_to_signed_rx.sv
// Directed self-checking bench for unsigned_to_signed_rx.
module tb_unsigned_to_signed_rx;
  logic        clk = 1'b0;
  logic        reset, en, sclk, cs_n, sdi;
  logic [15:0] off1, off2;
  logic        overrun, frame_err;
  int          n_checks = 0;
  int          n_fail   = 0;

  unsigned_to_signed_rx_if smp ();

  unsigned_to_signed_rx #(.FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .sdi       (sdi),
    .off1      (off1),
    .off2      (off2),
    .smp       (smp),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [15:0] word, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < 16) ? word[15-i] : 1'b0;
      wait_cyc(2);
      sclk = 1'b1;
      wait_cyc(3);
      sclk = 1'b0;
      wait_cyc(2);
    end
  endtask

  task automatic frame(input logic [15:0] word, input int nbits);
    $display("frame word=%h bits=%0d en=%0b", word, nbits, en);
    cs_n = 1'b0;
    wait_cyc(3);
    send_bits(word, nbits);
    cs_n = 1'b1;
  endtask

  // Sends a good frame and checks valid appears exactly on the expected cycle
  task automatic rx_check(input string tag, input logic [15:0] word, input logic is_b,
                          input logic [15:0] exp);
    frame(word, 16);
    wait_cyc(4);
    chk({tag, "_early"}, 16'(is_b ? smp.valid_b : smp.valid_a), 16'd0);
    wait_cyc(1);
    chk({tag, "_valid"}, 16'(is_b ? smp.valid_b : smp.valid_a), 16'd1);
    chk({tag, "_sample"}, is_b ? smp.sample_b : smp.sample_a, exp);
  endtask

  task automatic consume(input string tag, input logic is_b);
    if (is_b) smp.ready_b = 1'b1; else smp.ready_a = 1'b1;
    wait_cyc(1);
    smp.ready_a = 1'b0;
    smp.ready_b = 1'b0;
    chk({tag, "_cleared"}, 16'(is_b ? smp.valid_b : smp.valid_a), 16'd0);
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; sclk = 1'b0; cs_n = 1'b1; sdi = 1'b0;
    off1 = 16'd0; off2 = 16'd0;
    smp.ready_a = 1'b0; smp.ready_b = 1'b0;
    wait_cyc(3);
    chk("rst_sample_a", smp.sample_a, 16'd0);
    chk("rst_sample_b", smp.sample_b, 16'd0);
    chk("rst_valid_a", 16'(smp.valid_a), 16'd0);
    chk("rst_valid_b", 16'(smp.valid_b), 16'd0);
    chk("rst_overrun", 16'(overrun), 16'd0);
    chk("rst_frame_err", 16'(frame_err), 16'd0);
    reset = 1'b0;
    wait_cyc(2);

    // channel A decode: 2048 - code (reserved bits set in the last one)
    rx_check("a_800", 16'h0800, 1'b0, 16'h0000);
    consume("a_800", 1'b0);
    rx_check("a_000", 16'h0000, 1'b0, 16'h0800);
    consume("a_000", 1'b0);
    rx_check("a_fff", 16'h7FFF, 1'b0, 16'hF801);
    consume("a_fff", 1'b0);

    // channel B decode: code - 2047
    rx_check("b_7ff", 16'h87FF, 1'b1, 16'h0000);
    chk("b_7ff_valid_a", 16'(smp.valid_a), 16'd0);
    consume("b_7ff", 1'b1);
    rx_check("b_000", 16'h8000, 1'b1, 16'hF801);
    consume("b_000", 1'b1);
    rx_check("b_fff", 16'hFFFF, 1'b1, 16'h0800);
    chk("b_fff_valid_a", 16'(smp.valid_a), 16'd0);
    consume("b_fff", 1'b1);

    // overrun: second A sample dropped while the first is unconsumed
    rx_check("ovr1", 16'h0800, 1'b0, 16'h0000);
    chk("ovr1_flag", 16'(overrun), 16'd0);
    frame(16'h0000, 16);
    wait_cyc(6);
    chk("ovr2_sample_kept", smp.sample_a, 16'h0000);
    chk("ovr2_valid", 16'(smp.valid_a), 16'd1);
    chk("ovr2_flag", 16'(overrun), 16'd1);
    consume("ovr", 1'b0);
    chk("ovr_sticky", 16'(overrun), 16'd1);

    // short and long frames are rejected with a single error pulse
    frame(16'h0800, 12);
    wait_cyc(3);
    chk("short_err", 16'(frame_err), 16'd1);
    wait_cyc(1);
    chk("short_err_pulse", 16'(frame_err), 16'd0);
    wait_cyc(2);
    chk("short_valid_a", 16'(smp.valid_a), 16'd0);
    frame(16'h8800, 18);
    wait_cyc(3);
    chk("long_err", 16'(frame_err), 16'd1);
    wait_cyc(1);
    chk("long_err_pulse", 16'(frame_err), 16'd0);
    wait_cyc(2);
    chk("long_valid_b", 16'(smp.valid_b), 16'd0);
    rx_check("after_err", 16'h8123, 1'b1, 16'hF924);
    consume("after_err", 1'b1);

    // en low ignores the frame; en dropping mid-frame does not
    en = 1'b0;
    frame(16'h0800, 16);
    wait_cyc(6);
    chk("en_off_valid_a", 16'(smp.valid_a), 16'd0);
    en = 1'b1;
    $display("frame word=0400 bits=16 en dropped mid-frame");
    cs_n = 1'b0;
    wait_cyc(3);
    en = 1'b0;
    send_bits(16'h0400, 16);
    cs_n = 1'b1;
    wait_cyc(5);
    chk("en_mid_valid_a", 16'(smp.valid_a), 16'd1);
    chk("en_mid_sample_a", smp.sample_a, 16'h0400);
    en = 1'b1;
    consume("en_mid", 1'b0);

    // reset after 8 bits discards the partial frame and clears the sticky overrun
    $display("partial frame word=ffff bits=8 then reset");
    cs_n = 1'b0;
    wait_cyc(3);
    send_bits(16'hFFFF, 8);
    reset = 1'b1;
    cs_n = 1'b1;
    wait_cyc(2);
    chk("mrst_overrun", 16'(overrun), 16'd0);
    chk("mrst_sample_a", smp.sample_a, 16'd0);
    chk("mrst_sample_b", smp.sample_b, 16'd0);
    reset = 1'b0;
    wait_cyc(3);
    chk("mrst_frame_err", 16'(frame_err), 16'd0);
    chk("mrst_valid_a", 16'(smp.valid_a), 16'd0);
    rx_check("mrst_next", 16'h0ABC, 1'b0, 16'hFD44);
    consume("mrst_next", 1'b0);

`ifdef OFFSET_REMOVE_EN
    off1 = 16'h7FF0;
    rx_check("off_sat", 16'h0FFF, 1'b0, 16'h8000);
    consume("off_sat", 1'b0);
    off1 = 16'd100;
    rx_check("off_100", 16'h0800, 1'b0, 16'hFF9C);
    consume("off_100", 1'b0);
`else
    off1 = 16'h7FF0;
    off2 = 16'd100;
    rx_check("off_ignored_a", 16'h0FFF, 1'b0, 16'hF801);
    consume("off_ignored_a", 1'b0);
    rx_check("off_ignored_b", 16'h87FF, 1'b1, 16'h0000);
    consume("off_ignored_b", 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
